// File: rtl/program_loader.sv
// program_loader: length-prefixed byte-stream loader that fills CPU RAM and holds the CPU in reset until done
// Ports: i_clk, i_reset (sync, active-high), i_start, i_in_valid/i_in_data/o_in_ready byte channel,
//        o_mem_addr/o_mem_data/o_mem_we RAM write port, o_cpu_hold, o_busy, o_done, o_err status levels.
// Build option: LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte after the data bytes.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_we,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TO = IW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LEN, DATA, SUM, DONE, ERR} state_t;
  state_t            r_state, w_next;
  logic [7:0]        r_left;
  logic [ADDR_W-1:0] r_ptr;
  logic [IW-1:0]     r_idle;
  logic              w_xfer, w_tmo;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif
  assign o_in_ready = r_state inside {LEN, DATA, SUM};
  assign w_xfer = i_in_valid && o_in_ready;
  // every state change into LEN/DATA/SUM comes from a transfer or an inactive state, so the idle count is already zero there
  assign w_tmo = TIMEOUT != 0 && o_in_ready && !w_xfer && r_idle + 1'b1 == TO;
  always_comb begin
    w_next = r_state;
    if (w_tmo) w_next = ERR;
    else
      case (r_state)
        IDLE, DONE, ERR: w_next = i_start ? LEN : r_state;
        LEN:             w_next = !w_xfer ? LEN : i_in_data == '0 ? ERR : DATA;
`ifdef LOADER_CHECKSUM_EN
        DATA:            w_next = w_xfer && r_left == 8'd1 ? SUM : DATA;
        SUM:             w_next = !w_xfer ? SUM : i_in_data == r_sum ? DONE : ERR;
`else
        DATA:            w_next = w_xfer && r_left == 8'd1 ? DONE : DATA;
`endif
        default:         w_next = IDLE;
      endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_left     <= '0;
      r_ptr      <= BASE_ADDR;
      r_idle     <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= BASE_ADDR;
      o_mem_data <= '0;
      o_cpu_hold <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_next;
      o_busy     <= w_next inside {LEN, DATA, SUM};
      o_done     <= w_next == DONE;
      o_err      <= w_next == ERR;
      o_cpu_hold <= w_next != DONE;
      r_idle     <= o_in_ready && !w_xfer ? r_idle + 1'b1 : '0;
      o_mem_we   <= r_state == DATA && w_xfer;
      if (r_state == LEN) begin
        r_left <= i_in_data;
        r_ptr  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
      if (r_state == DATA && w_xfer) begin
        o_mem_addr <= r_ptr;
        o_mem_data <= i_in_data;
        r_ptr      <= r_ptr + 1'b1;
        r_left     <= r_left - 1'b1;
`ifdef LOADER_CHECKSUM_EN
        r_sum      <= r_sum + i_in_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives three loaders (bases 00, FE, 10) with one stream and checks them against a byte-level model
module tb_program_loader;
  localparam int TMO = 20;
  localparam int M_IDLE = 0, M_LEN = 1, M_DATA = 2, M_SUM = 3, M_DONE = 4, M_ERR = 5;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
  logic [7:0] din = '0;
  logic rdy [3], we [3], hold [3], busy [3], done [3], err [3];
  logic [7:0] addr [3], dat [3];
  int n_cmp = 0, n_bad = 0;
  int wn [3] = '{0, 0, 0};
  logic [7:0] wla [3][512], wld [3][512];
  int m_mode, m_left, m_off, m_sum, m_idle, m_woff;
  bit m_we, m_live = 1'b0;
  logic [7:0] m_wdata;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    program_loader #(
      .ADDR_W(8),
      .BASE_ADDR(g == 0 ? 8'h00 : g == 1 ? 8'hFE : 8'h10),
      .TIMEOUT(TMO)
    ) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_in_valid(valid), .i_in_data(din),
      .o_in_ready(rdy[g]), .o_mem_addr(addr[g]), .o_mem_data(dat[g]), .o_mem_we(we[g]),
      .o_cpu_hold(hold[g]), .o_busy(busy[g]), .o_done(done[g]), .o_err(err[g])
    );
  end
  function automatic int base_of(input int g);
    return g == 0 ? 'h00 : g == 1 ? 'hFE : 'h10;
  endfunction
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask
  // byte-level model: phase, bytes left, write offset, running sum, idle cycles
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_we = 1'b0; m_woff = 0; m_wdata = '0; m_idle = 0; m_live = 1'b1;
    end else begin
      int nm;
      bit act, x;
      act = m_mode == M_LEN || m_mode == M_DATA || m_mode == M_SUM;
      x = act && valid;
      nm = m_mode;
      m_we = 1'b0;
      if (!act) begin
        if (start) nm = M_LEN;
      end else if (x) begin
        if (m_mode == M_LEN) begin
          if (din == 8'd0) nm = M_ERR;
          else begin m_left = din; m_off = 0; m_sum = 0; nm = M_DATA; end
        end else if (m_mode == M_DATA) begin
          m_we = 1'b1; m_woff = m_off; m_wdata = din; m_off++;
          m_sum = (m_sum + din) % 256; m_left--;
          if (m_left == 0) nm = CK ? M_SUM : M_DONE;
        end else nm = din == m_sum[7:0] ? M_DONE : M_ERR;
      end
      if (act && !x) begin
        m_idle++;
        if (m_idle == TMO) nm = M_ERR;
      end else m_idle = 0;
      if (nm != m_mode) m_idle = 0;
      m_mode = nm;
    end
  end
  always @(negedge clk) begin
    if (m_live) for (int g = 0; g < 3; g++) begin
      chk("in_ready", g, rdy[g], m_mode == M_LEN || m_mode == M_DATA || m_mode == M_SUM);
      chk("busy", g, busy[g], m_mode == M_LEN || m_mode == M_DATA || m_mode == M_SUM);
      chk("done", g, done[g], m_mode == M_DONE);
      chk("err", g, err[g], m_mode == M_ERR);
      chk("cpu_hold", g, hold[g], m_mode != M_DONE);
      chk("mem_we", g, we[g], m_we);
      chk("mem_addr", g, addr[g], (base_of(g) + m_woff) % 256);
      chk("mem_data", g, dat[g], m_wdata);
      if (we[g] === 1'b1 && wn[g] < 512) begin
        wla[g][wn[g]] = addr[g]; wld[g][wn[g]] = dat[g]; wn[g]++;
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [7:0] b);
    valid = 1'b1; din = b; tick();
  endtask
  task automatic do_load(input logic [7:0] q[$]);
    start = 1'b1; tick(); start = 1'b0;
    foreach (q[i]) send(q[i]);
    valid = 1'b0; din = '0;
    tick(); tick();
  endtask
  initial begin
    logic [7:0] q[$];
    int n0;
    tick(); tick(); rst = 1'b0;
    chk("rst_hold", 0, hold[0], 1);
    chk("rst_addr", 1, addr[1], 8'hFE);
    chk("rst_ready", 2, rdy[2], 0);
    // 3-byte load, back-to-back
    n0 = wn[0];
    q = '{8'h03, 8'h0E, 8'h2F, 8'hE0};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h1D);
`endif
    do_load(q);
    chk("t1_nwr", 0, wn[0] - n0, 3);
    chk("t1_a0", 0, wla[0][n0], 8'h00);
    chk("t1_d0", 0, wld[0][n0], 8'h0E);
    chk("t1_a2", 0, wla[0][n0+2], 8'h02);
    chk("t1_d2", 0, wld[0][n0+2], 8'hE0);
    chk("t1_a2", 1, wla[1][n0+2], 8'h00);
    chk("t1_done", 0, done[0], 1);
    chk("t1_hold", 0, hold[0], 0);
    chk("t1_err", 0, err[0], 0);
`ifdef LOADER_CHECKSUM_EN
    // bad checksum: data still written, then ERR
    n0 = wn[0];
    do_load('{8'h03, 8'h0E, 8'h2F, 8'hE0, 8'h1C});
    chk("t2_nwr", 0, wn[0] - n0, 3);
    chk("t2_err", 0, err[0], 1);
    chk("t2_hold", 0, hold[0], 1);
    chk("t2_done", 0, done[0], 0);
`endif
    // 4-byte load, wraps for base FE
    n0 = wn[0];
    q = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'hAA);
`endif
    do_load(q);
    chk("t3_a0", 1, wla[1][n0], 8'hFE);
    chk("t3_a1", 1, wla[1][n0+1], 8'hFF);
    chk("t3_a2", 1, wla[1][n0+2], 8'h00);
    chk("t3_a3", 1, wla[1][n0+3], 8'h01);
    chk("t3_d3", 1, wld[1][n0+3], 8'h44);
    chk("t3_done", 1, done[1], 1);
    // zero length then a valid 1-byte load
    n0 = wn[0];
    do_load('{8'h00});
    chk("t4_err", 0, err[0], 1);
    chk("t4_nowe", 0, wn[0] - n0, 0);
    q = '{8'h01, 8'h5A};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h5A);
`endif
    do_load(q);
    chk("t4_done", 0, done[0], 1);
    chk("t4_a0", 2, wla[2][n0], 8'h10);
    // stall mid-load until timeout
    n0 = wn[0];
    start = 1'b1; tick(); start = 1'b0;
    send(8'h05); send(8'hA1); send(8'hA2);
    valid = 1'b0;
    repeat (25) tick();
    chk("t5_err", 0, err[0], 1);
    chk("t5_nwr", 0, wn[0] - n0, 2);
    // start during a load is ignored; reset aborts
    n0 = wn[0];
    start = 1'b1; tick(); start = 1'b0;
    send(8'h08); send(8'h01);
    start = 1'b1; send(8'h02); start = 1'b0;
    din = 8'h03; rst = 1'b1; tick(); tick(); rst = 1'b0; valid = 1'b0;
    repeat (4) tick();
    chk("t6_nwr", 0, wn[0] - n0, 2);
    chk("t6_busy", 0, busy[0], 0);
    chk("t6_hold", 0, hold[0], 1);
    chk("t6_addr", 2, addr[2], 8'h10);
    // 255-byte load wraps around the address space
    n0 = wn[0];
    q = '{8'hFF};
    for (int i = 0; i < 255; i++) q.push_back(8'(i));
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h81);
`endif
    do_load(q);
    chk("t7_nwr", 2, wn[2] - n0, 255);
    chk("t7_last", 2, wla[2][n0+254], 8'h0E);
    chk("t7_last", 1, wla[1][n0+254], 8'hFC);
    chk("t7_last", 0, wld[0][n0+254], 8'hFE);
    chk("t7_done", 2, done[2], 1);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
